// File: rtl/stopwatch_controller_pkg.sv
// stopwatch_controller_pkg: shared state encoding, digit geometry and BCD step helper
package stopwatch_controller_pkg;
    localparam int BCD_W  = 4;
    localparam int DIGITS = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    function automatic logic [BCD_W-1:0] digit_next(input logic [BCD_W-1:0] d, input logic inc,
                                                   input logic clr, input int max);
        return clr ? '0 : !inc ? d : (d == BCD_W'(max)) ? '0 : d + 1'b1;
    endfunction
endpackage

// File: rtl/stopwatch_controller_if.sv
// stopwatch_controller_if: divider/button inputs and display outputs of the stopwatch controller
interface stopwatch_controller_if;
    import stopwatch_controller_pkg::*;
    logic                      clk_100hz_in;
    logic                      btn_start;
    logic                      btn_lap;
    logic                      btn_clear;
    logic [BCD_W*DIGITS-1:0]   disp_bcd;
    logic                      running;
    logic                      lap_active;
    logic                      wrap;

    modport master (
        output clk_100hz_in, btn_start, btn_lap, btn_clear,
        input  disp_bcd, running, lap_active, wrap
    );
    modport slave (
        input  clk_100hz_in, btn_start, btn_lap, btn_clear,
        output disp_bcd, running, lap_active, wrap
    );
endinterface

// File: rtl/stopwatch_controller_bcd_digit_counter.sv
// bcd_digit_counter: one BCD digit 0..MAX with synchronous clear and a carry-out on rollover
module bcd_digit_counter
    import stopwatch_controller_pkg::*;
#(
    parameter int MAX = 9
) (
    input  logic             clk_in,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) digit <= '0;
        else      digit <= digit_next(digit, inc, clr, MAX);
    end

    assign carry = inc & (digit == BCD_W'(MAX));
endmodule

// File: rtl/stopwatch_controller.sv
// stopwatch_controller: edge detection, RUN/PAUSE/IDLE sequencing, BCD count and lap-frozen display
module stopwatch_controller
    import stopwatch_controller_pkg::*;
#(
    parameter int SEC_TENS_MAX = 5
) (
    input logic                  clk_in,
    input logic                  rst,
    stopwatch_controller_if.slave bus
);
    logic [3:0] lvl, prev, pulse;
    logic       armed, tick, start_p, lap_p, clear_p;
    state_t     state_q, state_d;
    logic       lap_q, lap_d, clr;
    logic [DIGITS-1:0] inc, carry;
    logic [BCD_W-1:0]  dig [DIGITS];
    logic [BCD_W-1:0]  nxt [DIGITS];

    assign lvl = {bus.clk_100hz_in, bus.btn_start, bus.btn_lap, bus.btn_clear};
    assign {tick, start_p, lap_p, clear_p} = pulse;

    // armed masks the first cycle after reset so levels already high never fire
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            armed <= 1'b0;
            prev  <= '0;
            pulse <= '0;
        end else begin
            armed <= 1'b1;
            prev  <= lvl;
            pulse <= {4{armed}} & lvl & ~prev;
        end
    end

    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            lap_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lap_q   <= lap_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lap_d   = lap_q;
        clr     = 1'b0;
        case (state_q)
            ST_IDLE:  state_d = start_p ? ST_RUN : ST_IDLE;
            ST_RUN: begin
                state_d = start_p ? ST_PAUSE : ST_RUN;
                lap_d   = (!start_p && lap_p) ? ~lap_q : lap_q;
            end
            ST_PAUSE: begin
                state_d = clear_p ? ST_IDLE : start_p ? ST_RUN : ST_PAUSE;
                lap_d   = clear_p ? 1'b0 : lap_q;
                clr     = clear_p;
            end
            default:  state_d = ST_IDLE;
        endcase
    end

    assign inc = {carry[DIGITS-2:0], tick & (state_q == ST_RUN)};

    genvar g;
    for (g = 0; g < DIGITS; g++) begin : g_dig
        localparam int M = (g == DIGITS - 1) ? SEC_TENS_MAX : 9;
        bcd_digit_counter #(.MAX(M)) u_digit (
            .clk_in(clk_in),
            .rst   (rst),
            .clr   (clr),
            .inc   (inc[g]),
            .digit (dig[g]),
            .carry (carry[g])
        );
        assign nxt[g] = digit_next(dig[g], inc[g], clr, M);
    end

    // display tracks the next count so it lines up with the digit registers; a lap freeze just holds it
    always_ff @(posedge clk_in or negedge rst) begin
        if (!rst) begin
            bus.disp_bcd <= '0;
            bus.running  <= 1'b0;
            bus.wrap     <= 1'b0;
        end else begin
            bus.disp_bcd <= lap_d ? bus.disp_bcd : {nxt[3], nxt[2], nxt[1], nxt[0]};
            bus.running  <= state_d == ST_RUN;
            bus.wrap     <= carry[DIGITS-1];
        end
    end

    assign bus.lap_active = lap_q;
endmodule

// File: tb/tb_stopwatch_controller.sv
// tb_stopwatch_controller: directed and random button/tick sequences checked against a centisecond model
module tb_stopwatch_controller;
    logic clk_in = 1'b0;
    logic rst    = 1'b0;
    stopwatch_controller_if bus();

    stopwatch_controller dut (
        .clk_in(clk_in),
        .rst   (rst),
        .bus   (bus.slave)
    );

    always #5 clk_in = ~clk_in;

    int compared = 0, mismatched = 0, wraps_seen = 0;
    int m_state = 0, m_cnt = 0, m_lap = 0, m_held = 0, m_wraps = 0;

    always @(negedge clk_in) if (bus.wrap === 1'b1) wraps_seen++;

    function automatic logic [15:0] bcd(input int n);
        return {4'(n / 1000), 4'((n / 100) % 10), 4'((n / 10) % 10), 4'(n % 10)};
    endfunction

    task automatic cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    // model: 0=idle 1=run 2=pause; count in centiseconds, 6000 wraps to 0
    task automatic m_apply(input bit t, input bit s, input bit l, input bit c);
        int old = m_cnt;
        if (t && m_state == 1) begin
            m_cnt = m_cnt + 1;
            if (m_cnt == 6000) begin
                m_cnt = 0;
                m_wraps++;
            end
        end
        if (m_state == 0) begin
            if (s) m_state = 1;
        end else if (m_state == 1) begin
            if (s) m_state = 2;
            else if (l) begin
                m_lap = !m_lap;
                if (m_lap) m_held = old;
            end
        end else if (c) begin
            m_state = 0;
            m_cnt   = 0;
            m_lap   = 0;
        end else if (s) m_state = 1;
    endtask

    task automatic m_reset();
        m_state = 0;
        m_cnt   = 0;
        m_lap   = 0;
        m_held  = 0;
    endtask

    task automatic step(input bit t, input bit s, input bit l, input bit c);
        bus.clk_100hz_in = t;
        bus.btn_start    = s;
        bus.btn_lap      = l;
        bus.btn_clear    = c;
        cyc(2);
        bus.clk_100hz_in = 1'b0;
        bus.btn_start    = 1'b0;
        bus.btn_lap      = 1'b0;
        bus.btn_clear    = 1'b0;
        cyc(2);
        m_apply(t, s, l, c);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".disp"}, 32'(bus.disp_bcd), 32'(m_lap ? bcd(m_held) : bcd(m_cnt)));
        chk({tag, ".running"}, 32'(bus.running), 32'(m_state == 1));
        chk({tag, ".lap_active"}, 32'(bus.lap_active), 32'(m_lap));
        chk({tag, ".wraps"}, 32'(wraps_seen), 32'(m_wraps));
    endtask

    initial begin
        bus.clk_100hz_in = 1'b0;
        bus.btn_start    = 1'b0;
        bus.btn_lap      = 1'b0;
        bus.btn_clear    = 1'b0;
        cyc(2);
        check_all("reset");
        chk("reset.wrap", 32'(bus.wrap), 32'd0);

        bus.clk_100hz_in = 1'b1;
        bus.btn_start    = 1'b1;
        cyc(1);
        #3 rst = 1'b1;
        cyc(3);
        check_all("level_high_at_release");
        bus.clk_100hz_in = 1'b0;
        bus.btn_start    = 1'b0;
        cyc(2);

        step(0, 1, 0, 0);
        check_all("start");
        repeat (123) step(1, 0, 0, 0);
        check_all("count_123");
        repeat (5876) step(1, 0, 0, 0);
        check_all("count_5999");
        step(1, 0, 0, 0);
        check_all("wrap");

        repeat (50) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        check_all("pause_50");
        repeat (10) step(1, 0, 0, 0);
        check_all("pause_hold");
        step(0, 1, 0, 1);
        check_all("start_clear_pause");

        step(0, 1, 0, 0);
        repeat (20) step(1, 0, 0, 0);
        check_all("run_20");
        step(0, 0, 1, 0);
        check_all("lap_set");
        repeat (30) step(1, 0, 0, 0);
        check_all("lap_hold");
        step(0, 0, 1, 0);
        check_all("lap_release");

        step(0, 1, 1, 0);
        check_all("start_lap_run");
        step(0, 0, 1, 0);
        check_all("lap_in_pause");
        step(0, 0, 0, 1);
        check_all("clear");

        step(0, 1, 0, 0);
        step(0, 0, 1, 0);
        repeat (7) step(1, 0, 0, 0);
        step(0, 1, 0, 0);
        check_all("freeze_kept_in_pause");
        step(0, 0, 0, 1);
        check_all("clear_releases_freeze");

        bus.btn_start = 1'b1;
        cyc(2);
        m_apply(0, 1, 0, 0);
        repeat (5) begin
            bus.clk_100hz_in = 1'b1;
            cyc(2);
            bus.clk_100hz_in = 1'b0;
            cyc(2);
            m_apply(1, 0, 0, 0);
        end
        bus.btn_start = 1'b0;
        cyc(2);
        check_all("held_start");
        step(0, 1, 0, 0);
        step(0, 0, 0, 1);

        step(1, 1, 0, 0);
        check_all("start_with_tick");
        step(1, 0, 0, 0);
        check_all("first_tick_after_start");

        for (int i = 0; i < 250; i++) begin
            step($urandom_range(0, 2) != 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            check_all($sformatf("random_%0d", i));
        end

        #2 rst = 1'b0;
        cyc(1);
        m_reset();
        #3 rst = 1'b1;
        cyc(2);
        check_all("rearm");
        step(0, 1, 0, 0);
        repeat (37) step(1, 0, 0, 0);
        check_all("count_37");
        #2 rst = 1'b0;
        #1;
        m_reset();
        check_all("async_reset");
        chk("async_reset.wrap", 32'(bus.wrap), 32'd0);
        #3 rst = 1'b1;
        cyc(2);
        check_all("after_async_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
